// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection and stop-bit framing check.
module uart_rx #(
  parameter int CLK_CNT  = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int BPS_CNT = CLK_CNT / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state, state_nx;
  logic        rxd_s1, rxd_s2, rxd_d;
  logic [2:0]  vld;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        start_cond, sample, bit_end;
  // vld marks when rxd_d holds a real line sample, so a line already low at reset release is not an edge
  assign start_cond = vld[2] & rxd_d & ~rxd_s2;
  assign sample     = timer == 16'(HALF);
  assign bit_end    = timer == 16'(BPS_CNT - 1);
  assign rx_busy    = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
      vld    <= '0;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
      vld    <= {vld[1:0], 1'b1};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_cond ? START : IDLE;
      START:   state_nx = (sample && rxd_s2) ? IDLE : bit_end ? DATA : START;
      DATA:    state_nx = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_nx = sample ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      timer     <= (state == IDLE || bit_end) ? '0 : timer + 16'd1;
      bit_idx   <= (state != DATA) ? '0 : bit_end ? bit_idx + 3'd1 : bit_idx;
      if (state == DATA && sample) shift[bit_idx] <= rxd_s2;
      if (state == STOP && sample && rxd_s2) rx_data <= shift;
      rx_done   <= state == STOP && sample && rxd_s2;
      frame_err <= state == STOP && sample && !rxd_s2;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_CNT, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, line baud rate.
REQ-003 The block SHALL derive localparam BPS_CNT = CLK_CNT / UART_BPS (434 at defaults) and HALF = BPS_CNT / 2 (217).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 rx_data  output  8  last correctly framed byte, held until the next valid frame.
REQ-008 rx_done  output  1  one-cycle pulse, rx_data valid from that cycle onward.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 rx_busy  output  1  high while a frame is being received.

Function
REQ-011 uart_rxd SHALL pass through a 2-flop synchronizer, with both flops reset to 1, before any use; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-012 A start condition SHALL be a synchronized falling edge (previous 1, current 0), detected only in IDLE.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 Transitions: IDLE->START on start condition; START->DATA at bit end if the start bit passed its check; DATA->STOP after bit 7 ends; STOP->IDLE at the stop-bit sample point.
REQ-015 A 16-bit bit-timer SHALL clear to 0 on entering START and count 0..BPS_CNT-1 per bit, wrapping to 0 at BPS_CNT-1 and advancing the bit.
REQ-016 Sampling SHALL occur when the timer equals HALF; all bits, including start and stop, are sampled once.
REQ-017 In START, a sample of 1 SHALL be treated as a glitch: return to IDLE with no pulse on any output.
REQ-018 In DATA, a 3-bit bit index SHALL count 0..7; sample k SHALL be written to shift/data bit k (LSB first).
REQ-019 In STOP, a sample of 1 SHALL load rx_data from the assembled byte and pulse rx_done for exactly one cycle.
REQ-020 In STOP, a sample of 0 SHALL pulse frame_err for one cycle and leave rx_data unchanged.
REQ-021 rx_done and frame_err SHALL never be high in the same cycle.
REQ-022 Return to IDLE at the stop sample point, rather than at stop-bit end, SHALL allow back-to-back frames with zero idle gap.
REQ-023 rx_busy SHALL be high in every state other than IDLE.
REQ-024 Latency: rx_done SHALL rise 2 sync cycles + 9*BPS_CNT + HALF (+/-1) clocks after the line falling edge.
REQ-025 A line held low after a frame_err SHALL NOT start a new frame until uart_rxd returns high and falls again.
REQ-026 The block SHALL tolerate +/-2% baud mismatch by virtue of mid-bit sampling; no resynchronization occurs within a frame.

Reset
REQ-027 rst_n low SHALL force, at any time including mid-frame, state=IDLE, timer=0, bit index=0, shift register=0x00, rx_data=0x00, rx_done=0, frame_err=0, rx_busy=0, and synchronizer flops=1.
REQ-028 After reset release, a line already low SHALL NOT be taken as a start bit; a falling edge is required.

Verification
REQ-029 Send 0x55 at 115200 baud -> rx_data=0x55, exactly one rx_done pulse, about 4124 clocks after the start edge, and frame_err stays 0.
REQ-030 Send 0xA5 then 0x3C back-to-back with no idle gap -> two rx_done pulses, rx_data=0xA5 then 0x3C.
REQ-031 Pulse the line low for 100 clocks, then return it high -> no rx_done or frame_err, and rx_busy returns to 0 about 217 clocks after the edge.
REQ-032 Send 0x81 with the stop bit forced to 0, after a prior valid 0x12 -> one frame_err pulse, rx_data stays 0x12, and no rx_done.
REQ-033 Assert rst_n for 10 clocks during data bit 4 of a frame -> all outputs return to reset values; the next full frame 0xF0 is received correctly.
REQ-034 Hold the line low for 20 bit times, then release it -> exactly one frame_err pulse and no further activity until the next falling edge.
